ers_pe_row_unit: RTL and testbench
==================================

ERS_PE_ROW_UNIT -- requirements
Module: ers_pe_row_unit

Interface
REQ-001 SHALL have parameter QUAN_BITS, default 8, signed weight width.
REQ-002 SHALL have parameter KSIZE, default 3, odd kernel row length; PAD=(KSIZE-1)/2.
REQ-003 SHALL have parameter TIME_STEPS, default 4, spike timesteps per column.
REQ-004 SHALL have parameter IMG_WIDTH, default 32, columns per spike row.
REQ-005 SHALL have parameter PSUM_BITS, default 16, signed psum width per timestep.
REQ-006 s_clk  in  1  clock; s_rst  in  1  reset, asynchronous, active-high.
REQ-007 i_weight_valid  in  1; i_weights  in  KSIZE*QUAN_BITS  w[k] = i_weights[k*QUAN_BITS +: QUAN_BITS].
REQ-008 i_spikes_valid  in  1; o_spikes_ready  out  1; i_spikes  in  IMG_WIDTH*TIME_STEPS  bit c*TIME_STEPS+t = column c, timestep t.
REQ-009 i_cal_start  in  1  start pulse; o_busy  out  1; o_done  out  1  one-cycle completion pulse.
REQ-010 o_psum_valid  out  1; i_psum_out_ready  in  1; o_psum  out  TIME_STEPS*PSUM_BITS  timestep t at [t*PSUM_BITS +: PSUM_BITS].

Function
REQ-011 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE; o_busy high outside IDLE.
REQ-012 IDLE: o_spikes_ready=1; spike row captured on i_spikes_valid; weights captured on i_weight_valid; both ignored in RUN/DRAIN.
REQ-013 Captured spikes SHALL be held unmodified (column selected by index, not shifted) so repeated runs reuse them.
REQ-014 i_cal_start in IDLE SHALL enter RUN next cycle with column counter 0; ignored in RUN/DRAIN.
REQ-015 Spike load, weight load and i_cal_start on the same IDLE edge: run SHALL use the newly loaded data.
REQ-016 Column c, timestep t result = sum over k of (spike[c+k-PAD][t] ? w[k] : 0); columns outside 0..IMG_WIDTH-1 read as zero.
REQ-017 Terms SHALL be sign-extended to PSUM_BITS; sum wraps two's complement.
REQ-018 Output register advance condition: RUN and (~o_psum_valid or i_psum_out_ready); on advance o_psum loads column c, o_psum_valid=1, counter increments.
REQ-019 While o_psum_valid=1 and i_psum_out_ready=0, o_psum, o_psum_valid and counter SHALL hold.
REQ-020 After column IMG_WIDTH-1 loads, FSM SHALL enter DRAIN; on final beat accepted, o_psum_valid=0, o_done=1 one cycle, IDLE.
REQ-021 Latency: first beat valid 2 cycles after i_cal_start; unstalled throughput one column/cycle; exactly IMG_WIDTH beats per run.

Reset
REQ-022 Reset SHALL force IDLE, weights 0, spike store 0, counter 0, o_psum 0, o_psum_valid 0, o_done 0, o_busy 0.
REQ-023 Reset mid-RUN/DRAIN SHALL abort immediately; no o_done; stored data lost.

Configuration
REQ-024 Macro ERS_PE_PSUM_CHAIN_EN defined: ports i_psum_in_valid (in 1), o_psum_in_ready (out 1), i_psum_in (in TIME_STEPS*PSUM_BITS) exist; per-timestep i_psum_in added (wrapping) to result; advance additionally requires i_psum_in_valid; o_psum_in_ready = advance.
REQ-025 Macro undefined: chain ports absent, result as REQ-016.

Structure
REQ-026 Shared package ers_pe_pkg SHALL hold FSM state enum and parameter defaults.
REQ-027 Sub-module ers_pe_tap_sum: one timestep's KSIZE spike-gated, sign-extended adder tree; instantiated TIME_STEPS times.

Verification (IMG_WIDTH=8, KSIZE=3, TIME_STEPS=4, QUAN_BITS=8, PSUM_BITS=16)
REQ-028 w={1,2,3}, all spikes 1, ready=1 -> col0=5, cols1-6=6, col7=3 all t; 8 beats; o_done once.
REQ-029 w={-1,4,-128}, single spike col3 t2 -> t2: col2=-128, col3=4, col4=-1; everything else 0.
REQ-030 REQ-028 with i_psum_out_ready low 5 cycles at col4 -> o_psum stable, no skip/duplicate, 8 beats.
REQ-031 Second i_cal_start, no spike reload, w={2,0,0} -> col0=0, cols1-7=2.
REQ-032 s_rst at col5 -> all outputs 0, IDLE, no o_done; next run without reload gives all zeros.
REQ-033 ERS_PE_PSUM_CHAIN_EN, i_psum_in=100 each t, REQ-028 spikes -> 105,106x6,103; i_psum_in_valid low stalls output.

Source files
------------

// File: rtl/ers_pe_pkg.sv
// Shared definitions for the ERS processing-element row unit.
// Holds the controller state encoding and the default parameter values
// used by ers_pe_row_unit and ers_pe_tap_sum.
package ers_pe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } pe_state_e;

  localparam int DEF_QUAN_BITS  = 8;
  localparam int DEF_KSIZE      = 3;
  localparam int DEF_TIME_STEPS = 4;
  localparam int DEF_IMG_WIDTH  = 32;
  localparam int DEF_PSUM_BITS  = 16;

endpackage

// File: rtl/ers_pe_tap_sum.sv
// One timestep's kernel-row accumulation.
// Each of the KSIZE weights is gated by its spike tap, sign-extended to
// PSUM_BITS and summed with two's-complement wrap.
// Ports:
//   i_taps    [KSIZE]            spike bit for each kernel tap
//   i_weights [KSIZE*QUAN_BITS]  signed weights, tap k at [k*QUAN_BITS +: QUAN_BITS]
//   o_sum     [PSUM_BITS]        wrapped sum of the gated weights
module ers_pe_tap_sum
  import ers_pe_pkg::*;
#(
  parameter int QUAN_BITS = DEF_QUAN_BITS,
  parameter int KSIZE     = DEF_KSIZE,
  parameter int PSUM_BITS = DEF_PSUM_BITS
) (
  input  logic [KSIZE-1:0]           i_taps,
  input  logic [KSIZE*QUAN_BITS-1:0] i_weights,
  output logic [PSUM_BITS-1:0]       o_sum
);

  logic signed [QUAN_BITS-1:0] w_s  [KSIZE];
  logic        [PSUM_BITS-1:0] term [KSIZE];

  genvar gi;
  generate
    for (gi = 0; gi < KSIZE; gi++) begin : g_term
      assign w_s[gi]  = i_weights[gi*QUAN_BITS +: QUAN_BITS];
      // Size cast of a signed operand sign-extends.
      assign term[gi] = i_taps[gi] ? PSUM_BITS'(w_s[gi]) : '0;
    end
  endgenerate

  always_comb begin
    o_sum = '0;
    for (int k = 0; k < KSIZE; k++) begin
      o_sum = o_sum + term[k];
    end
  end

endmodule

// File: rtl/ers_pe_row_unit.sv
// Spiking PE row unit: convolves a stored spike row with a KSIZE-tap weight
// row, producing one column of TIME_STEPS partial sums per output beat.
// Optional feature macro: ERS_PE_PSUM_CHAIN_EN adds an upstream psum input
// that is added per timestep to each column result.
// Ports:
//   s_clk, s_rst                      clock, asynchronous active-high reset
//   i_weight_valid, i_weights         weight row load (IDLE only)
//   i_spikes_valid, o_spikes_ready, i_spikes   spike row load (IDLE only)
//   i_cal_start, o_busy, o_done       run control and completion pulse
//   o_psum_valid, i_psum_out_ready, o_psum     output column stream
//   i_psum_in_valid, o_psum_in_ready, i_psum_in (chain build only)
module ers_pe_row_unit
  import ers_pe_pkg::*;
#(
  parameter int QUAN_BITS  = DEF_QUAN_BITS,
  parameter int KSIZE      = DEF_KSIZE,
  parameter int TIME_STEPS = DEF_TIME_STEPS,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int PSUM_BITS  = DEF_PSUM_BITS
) (
  input  logic                            s_clk,
  input  logic                            s_rst,
  input  logic                            i_weight_valid,
  input  logic [KSIZE*QUAN_BITS-1:0]      i_weights,
  input  logic                            i_spikes_valid,
  output logic                            o_spikes_ready,
  input  logic [IMG_WIDTH*TIME_STEPS-1:0] i_spikes,
  input  logic                            i_cal_start,
  output logic                            o_busy,
  output logic                            o_done,
`ifdef ERS_PE_PSUM_CHAIN_EN
  input  logic                            i_psum_in_valid,
  output logic                            o_psum_in_ready,
  input  logic [TIME_STEPS*PSUM_BITS-1:0] i_psum_in,
`endif
  output logic                            o_psum_valid,
  input  logic                            i_psum_out_ready,
  output logic [TIME_STEPS*PSUM_BITS-1:0] o_psum
);

  localparam int PAD = (KSIZE - 1) / 2;
  localparam int CW  = $clog2(IMG_WIDTH) + 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);

  pe_state_e                       state_q, state_d;
  logic [KSIZE*QUAN_BITS-1:0]      weights_q, weights_d;
  logic [IMG_WIDTH*TIME_STEPS-1:0] spikes_q, spikes_d;
  logic [CW-1:0]                   col_q, col_d;
  logic [TIME_STEPS*PSUM_BITS-1:0] psum_q, psum_d;
  logic                            valid_q, valid_d;
  logic                            done_q, done_d;

  logic                            advance;
  logic                            in_ok;
  logic [KSIZE-1:0]                taps    [TIME_STEPS];
  logic [PSUM_BITS-1:0]            tap_sum [TIME_STEPS];
  logic [TIME_STEPS*PSUM_BITS-1:0] row_sum;

  // Gather the KSIZE-wide spike window around the current column; the
  // store is indexed rather than shifted so it survives repeated runs.
  always_comb begin
    for (int t = 0; t < TIME_STEPS; t++) begin
      for (int k = 0; k < KSIZE; k++) begin
        int col;
        col        = int'(col_q) + k - PAD;
        taps[t][k] = 1'b0;
        if (col >= 0 && col < IMG_WIDTH) begin
          taps[t][k] = spikes_q[col*TIME_STEPS + t];
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < TIME_STEPS; gi++) begin : g_ts
      ers_pe_tap_sum #(
        .QUAN_BITS (QUAN_BITS),
        .KSIZE     (KSIZE),
        .PSUM_BITS (PSUM_BITS)
      ) u_tap_sum (
        .i_taps    (taps[gi]),
        .i_weights (weights_q),
        .o_sum     (tap_sum[gi])
      );
`ifdef ERS_PE_PSUM_CHAIN_EN
      assign row_sum[gi*PSUM_BITS +: PSUM_BITS] = tap_sum[gi] + i_psum_in[gi*PSUM_BITS +: PSUM_BITS];
`else
      assign row_sum[gi*PSUM_BITS +: PSUM_BITS] = tap_sum[gi];
`endif
    end
  endgenerate

`ifdef ERS_PE_PSUM_CHAIN_EN
  assign in_ok           = i_psum_in_valid;
  assign o_psum_in_ready = advance;
`else
  assign in_ok = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    weights_d = weights_q;
    spikes_d  = spikes_q;
    col_d     = col_q;
    psum_d    = psum_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    advance   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_weight_valid) weights_d = i_weights;
        if (i_spikes_valid) spikes_d = i_spikes;
        if (i_cal_start) begin
          state_d = ST_RUN;
          col_d   = '0;
        end
      end
      ST_RUN: begin
        advance = (~valid_q | i_psum_out_ready) & in_ok;
        if (advance) begin
          psum_d  = row_sum;
          valid_d = 1'b1;
          col_d   = col_q + CW'(1);
          if (col_q == LAST_COL) state_d = ST_DRAIN;
        end else if (valid_q && i_psum_out_ready) begin
          // Beat taken but no upstream psum yet: leave a bubble rather
          // than present the same column twice.
          valid_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (valid_q && i_psum_out_ready) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      state_q   <= ST_IDLE;
      weights_q <= '0;
      spikes_q  <= '0;
      col_q     <= '0;
      psum_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      weights_q <= weights_d;
      spikes_q  <= spikes_d;
      col_q     <= col_d;
      psum_q    <= psum_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign o_spikes_ready = (state_q == ST_IDLE);
  assign o_busy         = (state_q != ST_IDLE);
  assign o_done         = done_q;
  assign o_psum_valid   = valid_q;
  assign o_psum         = psum_q;

endmodule

// File: tb/tb_ers_pe_row_unit.sv
module tb_ers_pe_row_unit;

  localparam int QB  = 8;
  localparam int KS  = 3;
  localparam int TS  = 4;
  localparam int IW  = 8;
  localparam int PB  = 16;
  localparam int PAD = 1;

  logic             s_clk = 1'b0;
  logic             s_rst;
  logic             i_weight_valid;
  logic [KS*QB-1:0] i_weights;
  logic             i_spikes_valid;
  logic             o_spikes_ready;
  logic [IW*TS-1:0] i_spikes;
  logic             i_cal_start;
  logic             o_busy;
  logic             o_done;
  logic             o_psum_valid;
  logic             i_psum_out_ready;
  logic [TS*PB-1:0] o_psum;
`ifdef ERS_PE_PSUM_CHAIN_EN
  logic             i_psum_in_valid;
  logic             o_psum_in_ready;
  logic [TS*PB-1:0] i_psum_in;
`endif

  ers_pe_row_unit #(
    .QUAN_BITS(QB), .KSIZE(KS), .TIME_STEPS(TS), .IMG_WIDTH(IW), .PSUM_BITS(PB)
  ) dut (
    .s_clk(s_clk), .s_rst(s_rst),
    .i_weight_valid(i_weight_valid), .i_weights(i_weights),
    .i_spikes_valid(i_spikes_valid), .o_spikes_ready(o_spikes_ready), .i_spikes(i_spikes),
    .i_cal_start(i_cal_start), .o_busy(o_busy), .o_done(o_done),
`ifdef ERS_PE_PSUM_CHAIN_EN
    .i_psum_in_valid(i_psum_in_valid), .o_psum_in_ready(o_psum_in_ready), .i_psum_in(i_psum_in),
`endif
    .o_psum_valid(o_psum_valid), .i_psum_out_ready(i_psum_out_ready), .o_psum(o_psum)
  );

  always #5 s_clk = ~s_clk;

  int tests = 0;
  int fails = 0;

  // Reference state: the weights and spike row the DUT should be holding.
  int wq [KS];
  bit sp [IW][TS];
  int chain_add = 0;
  bit chain_rnd = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected column: convolution of the stored row with the weights,
  // zero-padded at the edges, wrapped to PB bits per timestep.
  function automatic logic [63:0] exp_row(input int c);
    logic [63:0] r;
    r = '0;
    for (int t = 0; t < TS; t++) begin
      int s;
      s = chain_add;
      for (int k = 0; k < KS; k++) begin
        int col;
        col = c + k - PAD;
        if (col >= 0 && col < IW && sp[col][t]) s += wq[k];
      end
      r[t*PB +: PB] = s[PB-1:0];
    end
    return r;
  endfunction

  task automatic set_w(input int a, input int b, input int c);
    wq[0] = a; wq[1] = b; wq[2] = c;
    i_weights      = {8'(c), 8'(b), 8'(a)};
    i_weight_valid = 1'b1;
  endtask

  task automatic push_spikes();
    for (int c = 0; c < IW; c++)
      for (int t = 0; t < TS; t++)
        i_spikes[c*TS + t] = sp[c][t];
    i_spikes_valid = 1'b1;
  endtask

  task automatic clear_inputs();
    i_weight_valid = 1'b0;
    i_spikes_valid = 1'b0;
    i_cal_start    = 1'b0;
`ifdef ERS_PE_PSUM_CHAIN_EN
    i_psum_in_valid = 1'b1;
`endif
  endtask

  // Starts a run (with whatever loads the caller staged on the same edge),
  // then checks every accepted beat against the model in order.
  task automatic run_check(input string name, input int stall_at, input int stall_len,
                           input bit rnd_ready, input bit junk, input bit chk_lat);
    int beat = 0, dones = 0, edges = 0, stall_cnt = 0, first_valid = -1;
    logic [63:0] prev_p = '0;
    bit prev_hold = 0, fin = 0, rdy;
    i_cal_start = 1'b1;
    @(posedge s_clk); #1;
    edges = 1;
    clear_inputs();
    chk({name, "_busy"}, 64'(o_busy), 64'd1);
    chk({name, "_spk_rdy_low"}, 64'(o_spikes_ready), 64'd0);
    while (!fin && edges < 300) begin
      if (o_psum_valid && first_valid < 0) first_valid = edges;
      rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall_len > 0 && beat == stall_at && o_psum_valid && stall_cnt < stall_len) begin
        rdy = 1'b0;
        stall_cnt++;
      end
      i_psum_out_ready = rdy;
      if (junk && o_busy) begin
        i_weight_valid = 1'b1; i_weights = 24'($urandom);
        i_spikes_valid = 1'b1; i_spikes  = $urandom;
        i_cal_start    = 1'($urandom_range(0, 1));
      end
`ifdef ERS_PE_PSUM_CHAIN_EN
      i_psum_in_valid = chain_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
`endif
      if (prev_hold) begin
        chk($sformatf("%s_hold_col%0d", name, beat), o_psum, prev_p);
        chk($sformatf("%s_hold_valid%0d", name, beat), 64'(o_psum_valid), 64'd1);
      end
      prev_hold = o_psum_valid && !rdy;
      prev_p    = o_psum;
      if (o_psum_valid && rdy) begin
        if (beat < IW) chk($sformatf("%s_col%0d", name, beat), o_psum, exp_row(beat));
        else           chk($sformatf("%s_extra_beat", name), 64'(beat), 64'(IW - 1));
        beat++;
      end
      @(posedge s_clk); #1;
      edges++;
      if (o_done) begin
        dones++;
        fin = 1;
      end
    end
    clear_inputs();
    i_psum_out_ready = 1'b1;
    chk({name, "_beats"}, 64'(beat), 64'(IW));
    chk({name, "_done_seen"}, 64'(dones), 64'd1);
    if (chk_lat) chk({name, "_latency"}, 64'(first_valid), 64'd2);
    chk({name, "_idle_busy"}, 64'(o_busy), 64'd0);
    chk({name, "_idle_valid"}, 64'(o_psum_valid), 64'd0);
    @(posedge s_clk); #1;
    chk({name, "_done_1cyc"}, 64'(o_done), 64'd0);
    $display("[TB] run %s: %0d beats, %0d done pulses, first valid at edge %0d", name, beat, dones, first_valid);
  endtask

  task automatic rand_data();
    set_w(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
          int'($urandom_range(0, 255)) - 128);
    for (int c = 0; c < IW; c++)
      for (int t = 0; t < TS; t++)
        sp[c][t] = 1'($urandom_range(0, 1));
    push_spikes();
  endtask

  initial begin
    s_rst            = 1'b1;
    i_weights        = '0;
    i_spikes         = '0;
    i_psum_out_ready = 1'b1;
`ifdef ERS_PE_PSUM_CHAIN_EN
    i_psum_in = '0;
`endif
    clear_inputs();
    for (int k = 0; k < KS; k++) wq[k] = 0;
    for (int c = 0; c < IW; c++) for (int t = 0; t < TS; t++) sp[c][t] = 1'b0;
    repeat (3) @(posedge s_clk);
    #1;
    chk("rst_psum", o_psum, 64'd0);
    chk("rst_valid", 64'(o_psum_valid), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_spk_rdy", 64'(o_spikes_ready), 64'd1);
    s_rst = 1'b0;
    @(posedge s_clk); #1;

    // All-ones row with loads on the same edge as the start pulse.
    set_w(1, 2, 3);
    for (int c = 0; c < IW; c++) for (int t = 0; t < TS; t++) sp[c][t] = 1'b1;
    push_spikes();
    run_check("all1", 0, 0, 0, 0, 1);

    // Same data reused; output stalled for 5 cycles at column 4.
    run_check("stall", 4, 5, 0, 0, 1);

    // New weights only; spike row kept from before.
    set_w(2, 0, 0);
    run_check("w200", 0, 0, 0, 0, 1);

    // Single spike at column 3, timestep 2, with extreme weights.
    set_w(-1, 4, -128);
    for (int c = 0; c < IW; c++) for (int t = 0; t < TS; t++) sp[c][t] = 1'b0;
    sp[3][2] = 1'b1;
    push_spikes();
    run_check("single", 0, 0, 0, 0, 1);

    // Random data, random backpressure, loads and starts poked during the run.
    for (int r = 0; r < 4; r++) begin
      rand_data();
      run_check($sformatf("rand%0d", r), 0, 0, 1, 1, 0);
    end

`ifdef ERS_PE_PSUM_CHAIN_EN
    chain_add = 100;
    chain_rnd = 1;
    i_psum_in = {4{16'd100}};
    set_w(1, 2, 3);
    for (int c = 0; c < IW; c++) for (int t = 0; t < TS; t++) sp[c][t] = 1'b1;
    push_spikes();
    run_check("chain", 0, 0, 0, 0, 0);
    chain_add = 0;
    chain_rnd = 0;
    i_psum_in = '0;
`endif

    // Reset in the middle of a run, with column 5 on the output.
    rand_data();
    i_psum_out_ready = 1'b1;
    i_cal_start = 1'b1;
    @(posedge s_clk); #1;
    clear_inputs();
    repeat (6) @(posedge s_clk);
    #1;
    chk("rst_mid_pre_col5", o_psum, exp_row(5));
    #2 s_rst = 1'b1;
    #1;
    chk("rst_mid_psum", o_psum, 64'd0);
    chk("rst_mid_valid", 64'(o_psum_valid), 64'd0);
    chk("rst_mid_busy", 64'(o_busy), 64'd0);
    chk("rst_mid_done", 64'(o_done), 64'd0);
    chk("rst_mid_spk_rdy", 64'(o_spikes_ready), 64'd1);
    @(posedge s_clk); #1;
    chk("rst_mid_done_after", 64'(o_done), 64'd0);
    s_rst = 1'b0;
    $display("[TB] mid-run reset applied at column 5");
    for (int k = 0; k < KS; k++) wq[k] = 0;
    for (int c = 0; c < IW; c++) for (int t = 0; t < TS; t++) sp[c][t] = 1'b0;
    @(posedge s_clk); #1;
    run_check("post_rst", 0, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
